axi_bridge_ooo: RTL
===================

Name: axi_bridge_ooo

Overview:
- Successor SRAM-like-to-AXI3 bridge between the CPU's inst/data SRAM-like ports and the single AXI master port.
- Allows up to RD_DEPTH outstanding reads per port and WR_DEPTH outstanding data writes, where the previous one-transaction-per-channel bridge allowed only one.
- Data-port responses always return in request order.
- Protects read-after-write ordering with an address-match check against queued writes.

Parameters:
ADDR_W, 32, address width of SRAM-like and AXI address ports
DATA_W, 32, data width (32 only; wstrb is DATA_W/8)
RD_DEPTH, 2, max outstanding reads per port (1..4)
WR_DEPTH, 2, max outstanding data writes (1..4)

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
inst_req, inst_wr  input  1,1  inst request; inst_wr ignored (inst port is read-only)
inst_size  input  2  0=byte 1=half 2=word
inst_addr, inst_wdata  input  ADDR_W, DATA_W  address; wdata unused
inst_rdata  output  DATA_W  read data, valid with inst_data_ok
inst_addr_ok, inst_data_ok  output  1,1  request accepted / response returned
data_req, data_wr  input  1,1  data request; 1=write
data_size, data_wen  input  2,4  size; byte write enables
data_addr, data_wdata  input  ADDR_W, DATA_W  address / write data
data_rdata  output  DATA_W  read data, valid with data_data_ok on a read
data_addr_ok, data_data_ok  output  1,1  accept / response (read or write)
arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid, arready  out/in  4/ADDR_W/4/3/2/2/4/3/1, 1  AXI read address channel
rid/rdata/rresp/rlast/rvalid, rready  in/out  4/DATA_W/2/1/1, 1  AXI read data channel
awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid, awready  out/in  widths as AR  AXI write address channel
wid/wdata/wstrb/wlast/wvalid, wready  out/in  4/DATA_W/4/1/1, 1  AXI write data channel
bid/bresp/bvalid, bready  in/out  4/2/1, 1  AXI write response channel

Behaviour:
- Reset (resetn=0 at posedge): arvalid, awvalid, wvalid=0; all counters, the order FIFO and the write-address queue empty. A reset mid-transaction drops all outstanding state; no data_ok is issued afterwards for pre-reset requests.
- IDs: inst reads arid=0. Data reads arid=1, awid=wid=1.
- Constants: arlen=awlen=0, arburst=awburst=2'b01, lock/cache/prot=0, wlast=1. arsize/awsize={1'b0,size}. wstrb=data_wen.
- AR slot: a single register. It is free when !arvalid || arready.
- Data read accept condition, data_addr_ok=1 when all hold: data_req && !data_wr; AR slot free; rd_cnt_d<RD_DEPTH; order FIFO not full; no queued write has addr[ADDR_W-1:2] equal to data_addr[ADDR_W-1:2].
- Inst read accept condition, inst_addr_ok=1 when all hold: inst_req; AR slot free; rd_cnt_i<RD_DEPTH; no data read is being accepted this cycle. Data has priority.
- Accepted read: loads AR next cycle (arvalid=1) and increments the per-port counter. Same-cycle increment and decrement cancel.
- Data write accept, data_addr_ok=1 when all hold: data_req && data_wr; awvalid=0 and wvalid=0 (or both completing this cycle); wr_cnt<WR_DEPTH; order FIFO not full.
- Accepted write: next cycle awvalid=wvalid=1. The address is pushed to the write-address queue.
- AW/W drop independently on their own handshakes.
- bvalid&&bready pops the write queue head and decrements wr_cnt.
- Order FIFO: depth RD_DEPTH+WR_DEPTH, 1 bit per data op (0=read, 1=write). It is pushed on every data accept.
- rready = (rid==0) ? 1 : (head==read). bready = head==write. A response whose kind does not match the head stalls until it becomes the head.
- data_data_ok = (rvalid&&rready&&rid==1) || (bvalid&&bready). It pops the FIFO.
- inst_data_ok = rvalid&&rid==0. inst_rdata=data_rdata=rdata.
- Latency: addr_ok is combinational in the request cycle. arvalid/awvalid assert the following cycle. data_ok is combinational with rvalid/bvalid.
- rresp/bresp are ignored. rid/bid values other than 0/1 are unsupported.

Test Plan:
- Single inst read 0xBFC00000, arready=1, rvalid 3 cycles later -> inst_addr_ok same cycle, arvalid next cycle with arid=0, inst_data_ok with rdata.
- Three back-to-back inst reads, slave withholds rvalid, RD_DEPTH=2 -> first two accepted, third has inst_addr_ok=0 until the first r beat, then accepted.
- Simultaneous inst and data read -> data accepted first (arid=1), inst accepted the next free AR slot.
- Data write 0x80001004 (wen=4'b0011, bvalid delayed 5 cycles), then data read 0x80001006 -> read addr_ok held 0 until the b handshake; a read to 0x80001008 is accepted immediately.
- Write then read to different words, slave returns r before b -> rready=0 for rid=1 until bready/b completes; data_data_ok order is write then read.
- resetn=0 with 2 reads outstanding -> all valids 0 next cycle; late rvalid produces no data_ok.

Source files
------------

// File: rtl/axi_bridge_ooo.sv
// SRAM-like to AXI3 bridge with multiple outstanding reads per port and
// outstanding data writes; data-port responses retire strictly in request order.
module axi_bridge_ooo #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_DEPTH = 2,
    parameter int WR_DEPTH = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);
    localparam int ORD_DEPTH = RD_DEPTH + WR_DEPTH;

    function automatic logic [3:0] cnt_step(input logic [3:0] cnt, input logic inc, input logic dec);
        logic [3:0] res;
        case ({inc, dec})
            2'b10:   res = cnt + 4'd1;
            2'b01:   res = cnt - 4'd1;
            default: res = cnt;
        endcase
        return res;
    endfunction

    logic              arvalid_r, awvalid_r, wvalid_r;
    logic [3:0]        arid_r, wstrb_r;
    logic [ADDR_W-1:0] araddr_r, awaddr_r;
    logic [2:0]        arsize_r, awsize_r;
    logic [DATA_W-1:0] wdata_r;
    logic [3:0]        rd_cnt_i_r, rd_cnt_d_r, wr_cnt_r, ord_cnt_r;
    // Order FIFO and write-address queue use fixed maximum storage; pointers wrap at the configured depth.
    logic [7:0]        ord_mem_r;
    logic [2:0]        ord_head_r, ord_tail_r;
    logic [ADDR_W-3:0] wq_addr_r [4];
    logic [3:0]        wq_vld_r;
    logic [1:0]        wq_head_r, wq_tail_r;

    logic ar_free_s, wq_hit_s, ord_full_s, ord_head_s, ord_nempty_s;
    logic d_rd_acc_s, i_rd_acc_s, d_wr_acc_s;
    logic i_rsp_s, d_rsp_s, b_fire_s, ord_push_s, ord_pop_s;

    // Accept decisions, response steering and queue hazard check.
    always_comb begin
        wq_hit_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wq_hit_s = wq_hit_s | (wq_vld_r[i] && (wq_addr_r[i] == data_addr[ADDR_W-1:2]));
        end
        ar_free_s    = !arvalid_r || arready;
        ord_full_s   = (ord_cnt_r == 4'(ORD_DEPTH));
        ord_nempty_s = (ord_cnt_r != 4'd0);
        ord_head_s   = ord_mem_r[ord_head_r];
        d_rd_acc_s   = data_req && !data_wr && ar_free_s && (rd_cnt_d_r < 4'(RD_DEPTH))
                       && !ord_full_s && !wq_hit_s;
        i_rd_acc_s   = inst_req && ar_free_s && (rd_cnt_i_r < 4'(RD_DEPTH)) && !d_rd_acc_s;
        d_wr_acc_s   = data_req && data_wr && (!awvalid_r || awready) && (!wvalid_r || wready)
                       && (wr_cnt_r < 4'(WR_DEPTH)) && !ord_full_s;
        rready       = (rid == 4'd0) ? 1'b1 : (ord_nempty_s && !ord_head_s);
        bready       = ord_nempty_s && ord_head_s;
        // Stray inst beats with nothing outstanding (e.g. after reset) are drained silently.
        i_rsp_s      = rvalid && (rid == 4'd0) && (rd_cnt_i_r != 4'd0);
        d_rsp_s      = rvalid && rready && (rid == 4'd1);
        b_fire_s     = bvalid && bready;
        ord_push_s   = d_rd_acc_s || d_wr_acc_s;
        ord_pop_s    = d_rsp_s || b_fire_s;
    end

    assign inst_addr_ok = i_rd_acc_s;
    assign data_addr_ok = d_rd_acc_s || d_wr_acc_s;
    assign inst_data_ok = i_rsp_s;
    assign data_data_ok = ord_pop_s;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = arid_r;
    assign araddr  = araddr_r;
    assign arsize  = arsize_r;
    assign arvalid = arvalid_r;
    assign arlen   = 4'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = 4'd1;
    assign awaddr  = awaddr_r;
    assign awsize  = awsize_r;
    assign awvalid = awvalid_r;
    assign awlen   = 4'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = 4'd1;
    assign wdata   = wdata_r;
    assign wstrb   = wstrb_r;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_r;

    // AR slot: data read wins, otherwise inst read, otherwise drop on handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            arvalid_r <= 1'b0;
            arid_r    <= 4'd0;
            araddr_r  <= '0;
            arsize_r  <= 3'd0;
        end else if (d_rd_acc_s) begin
            arvalid_r <= 1'b1;
            arid_r    <= 4'd1;
            araddr_r  <= data_addr;
            arsize_r  <= {1'b0, data_size};
        end else if (i_rd_acc_s) begin
            arvalid_r <= 1'b1;
            arid_r    <= 4'd0;
            araddr_r  <= inst_addr;
            arsize_r  <= {1'b0, inst_size};
        end else if (arready) begin
            arvalid_r <= 1'b0;
        end
    end

    // AW and W registers load together and retire on their own handshakes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            awaddr_r  <= '0;
            awsize_r  <= 3'd0;
            wdata_r   <= '0;
            wstrb_r   <= 4'd0;
        end else if (d_wr_acc_s) begin
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
            awaddr_r  <= data_addr;
            awsize_r  <= {1'b0, data_size};
            wdata_r   <= data_wdata;
            wstrb_r   <= data_wen;
        end else begin
            if (awready) awvalid_r <= 1'b0;
            if (wready)  wvalid_r  <= 1'b0;
        end
    end

    // Outstanding counters and the read/write order FIFO.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_cnt_i_r <= 4'd0;
            rd_cnt_d_r <= 4'd0;
            wr_cnt_r   <= 4'd0;
            ord_cnt_r  <= 4'd0;
            ord_head_r <= 3'd0;
            ord_tail_r <= 3'd0;
            ord_mem_r  <= 8'd0;
        end else begin
            rd_cnt_i_r <= cnt_step(rd_cnt_i_r, i_rd_acc_s, i_rsp_s);
            rd_cnt_d_r <= cnt_step(rd_cnt_d_r, d_rd_acc_s, d_rsp_s);
            wr_cnt_r   <= cnt_step(wr_cnt_r, d_wr_acc_s, b_fire_s);
            ord_cnt_r  <= cnt_step(ord_cnt_r, ord_push_s, ord_pop_s);
            if (ord_push_s) begin
                ord_mem_r[ord_tail_r] <= data_wr;
                ord_tail_r <= (ord_tail_r == 3'(ORD_DEPTH - 1)) ? 3'd0 : ord_tail_r + 3'd1;
            end
            if (ord_pop_s) begin
                ord_head_r <= (ord_head_r == 3'(ORD_DEPTH - 1)) ? 3'd0 : ord_head_r + 3'd1;
            end
        end
    end

    // Word addresses of writes not yet acknowledged on B.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wq_vld_r  <= 4'd0;
            wq_head_r <= 2'd0;
            wq_tail_r <= 2'd0;
            for (int i = 0; i < 4; i++) wq_addr_r[i] <= '0;
        end else begin
            if (d_wr_acc_s) begin
                wq_vld_r[wq_tail_r]  <= 1'b1;
                wq_addr_r[wq_tail_r] <= data_addr[ADDR_W-1:2];
                wq_tail_r <= (wq_tail_r == 2'(WR_DEPTH - 1)) ? 2'd0 : wq_tail_r + 2'd1;
            end
            if (b_fire_s) begin
                wq_vld_r[wq_head_r] <= 1'b0;
                wq_head_r <= (wq_head_r == 2'(WR_DEPTH - 1)) ? 2'd0 : wq_head_r + 2'd1;
            end
        end
    end
endmodule
